serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add controller that time-shares a single full_adder cell to add two WIDTH-bit operands, LSB first, one bit per clock.
- Holds the operand shift registers, the carry flip-flop, a bit counter and a start/busy/done handshake.
- Sits between a requesting datapath and the existing combinational full_adder, trading latency (WIDTH cycles) for area.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when busy=0
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  result of the last completed addition
- cout  output  1  carry-out of the last completed addition

Behaviour:
- Reset: rst_n low clears all state asynchronously. FSM goes to IDLE; busy=0, done=0, sum=0, cout=0, counter=0, carry FF=0, shift registers=0.
- FSM states:
  - IDLE: busy=0, done=0. On an edge with start=1, load shift_a<=a, shift_b<=b, carry<=cin, counter<=0, shift_s<=0, and go to RUN.
  - RUN: busy=1. Each edge does all of the following:
    - Feeds shift_a[0], shift_b[0] and carry into the full_adder instance.
    - Writes the adder's sum bit into shift_s[WIDTH-1], shifting shift_s right.
    - Shifts shift_a and shift_b right.
    - Sets carry<=cout_fa and counter<=counter+1.
  - RUN exit: on the edge where counter==WIDTH-1, the final bit is processed, sum<=shifted result, cout<=cout_fa, and the FSM goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. If start=1 on that edge, it is accepted exactly as in IDLE and the FSM goes to RUN (back-to-back operation); otherwise it goes to IDLE.
- Latency: with acceptance at edge E0, bits are processed at E1..E_WIDTH. done is high from E_WIDTH to E_WIDTH+1, and sum/cout update at E_WIDTH.
- Throughput: one addition per WIDTH+1 cycles when start is held high.
- sum and cout change only at completion. They are stable throughout RUN and IDLE and show the previous result until the next completion.
- start while busy=1 is ignored: no queuing and no effect on the current operation.
- Changes to a, b or cin after the accepting edge have no effect.
- Arithmetic is unsigned modulo 2**WIDTH, with overflow reported only in cout. The counter never exceeds WIDTH-1.
- Reset asserted mid-RUN aborts immediately. Outputs return to reset values, no done pulse is produced, and the aborted result is lost.

Decomposition:
- Shared constants file (included by this block and its bench): FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
- Sub-module: one instance of the existing full_adder (ports a, b, cin, cout, sum) as the sole arithmetic element. No other adders are permitted in this block.
- Everything else (FSM, counter, shift registers) stays in serial_add_ctrl.

Test Plan:
- a=8'h5A, b=8'h3C, cin=0, start pulsed one cycle -> busy high for 8 cycles; done pulses once at E8; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 at E8. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start held high continuously with alternating operands (8'h10+8'h20, then 8'h7F+8'h01) -> done every 9 cycles; results 8'h30/0 then 8'h80/0; no cycle is lost between operations.
- start and new operands applied at E3 of a busy operation (8'h01+8'h01) -> ignored. First result 8'h02 arrives at E8, and no second done follows.
- rst_n pulled low at E4 of 8'hAA+8'h55 -> busy, done, sum and cout are 0 asynchronously. After release, an idle start of 8'h0F+8'h01 gives 8'h10 with no stale carry.
- a, b and cin toggled randomly during RUN after accepting 8'hC3+8'h3C, cin=1 -> sum=8'h00, cout=1, proving the operands are captured at acceptance.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: FSM state encodings shared by the serial adder controller and its bench
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, LSB first, one full_adder time-shared over WIDTH cycles
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_a, shift_b, shift_s;
    logic [CNT_W-1:0] cnt;
    logic             carry, s_bit, c_bit, accept, last;

    full_adder u_fa (
        .a   (shift_a[0]),
        .b   (shift_b[0]),
        .cin (carry),
        .cout(c_bit),
        .sum (s_bit)
    );

    // DONE accepts a new request exactly like IDLE, giving back-to-back operation
    always_comb begin
        state_nxt = ST_IDLE;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                accept    = start;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                last      = cnt == CNT_W'(WIDTH - 1);
                state_nxt = last ? ST_DONE : ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = state == ST_RUN;
    assign done = state == ST_DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shift_a <= '0;
            shift_b <= '0;
            shift_s <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shift_a <= a;
                shift_b <= b;
                shift_s <= '0;
                carry   <= cin;
                cnt     <= '0;
            end else if (state == ST_RUN) begin
                shift_a <= shift_a >> 1;
                shift_b <= shift_b >> 1;
                shift_s <= {s_bit, shift_s[WIDTH-1:1]};
                carry   <= c_bit;
                cnt     <= last ? '0 : cnt + CNT_W'(1);
            end
            if (last) begin
                sum  <= {s_bit, shift_s[WIDTH-1:1]};
                cout <= c_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed scoreboard bench for the bit-serial add controller
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    logic [WIDTH:0]   q[$];
    logic [WIDTH:0]   last_exp = '0;
    logic [WIDTH:0]   popped;
    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;

    serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every done pulse; while busy the previous result must hold still
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    popped = q.pop_front();
                    chk("result", {cout, sum}, popped);
                    last_exp = popped;
                end
            end else if (busy) begin
                chk("hold_during_run", {cout, sum}, last_exp);
            end
        end
    end

    task automatic wait_done(output int t, output bit ok, output int bcnt, input bit scramble);
        ok = 1'b0;
        bcnt = 0;
        t = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                t = cyc;
            end else begin
                if (busy) bcnt++;
                if (scramble) begin
                    a = WIDTH'($urandom);
                    b = WIDTH'($urandom);
                    cin = 1'($urandom);
                end
            end
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic go(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                      input logic [WIDTH:0] exp, input bit scramble);
        int t, bcnt;
        bit ok;
        @(posedge clk);
        #1;
        a = xa;
        b = xb;
        cin = xc;
        start = 1'b1;
        q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(t, ok, bcnt, scramble);
        chk("busy_cycles", 32'(bcnt), WIDTH);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int t1, t2, bcnt, dcnt;
        bit ok;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        go(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b0);
        go(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
        go(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);

        // start held high: second operation accepted on the DONE edge
        @(posedge clk);
        #1;
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        q.push_back(9'h030);
        q.push_back(9'h080);
        @(posedge clk);
        #1;
        a = 8'h7F;
        b = 8'h01;
        wait_done(t1, ok, bcnt, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(t2, ok, bcnt, 1'b0);
        chk("b2b_spacing", 32'(t2 - t1), WIDTH + 1);

        // start while busy is ignored
        @(posedge clk);
        #1;
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        q.push_back(9'h002);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(t1, ok, bcnt, 1'b0);
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_second_done", 32'(dcnt), 32'd0);

        // reset mid-run aborts and clears everything
        @(posedge clk);
        #1;
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b1;
        start = 1'b1;
        q.push_back(9'h100);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        q.delete();
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        go(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0);

        go(8'hC3, 8'h3C, 1'b1, 9'h100, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
